rv32_mc_control_unit: RTL and testbench
=======================================

# rv32_mc_control_unit

Multi-cycle RV32I control unit. It sequences every instruction through FETCH/DECODE/EXECUTE/MEM/WB and drives the datapath enables and ALU opcode from a latched instruction word. Compared with the single-cycle decoder, it adds B/LU/AU/J/JL types, a data-memory ready handshake with a timeout watchdog, and illegal-opcode reporting. It sits beside the datapath in the CPU core, between the instruction register and the PC/regfile/ALU/data-memory enables.

## Interface
Parameters:
- `ALU_CTRL_W`, default 4: width of `aluControl`, ≥4; upper bits zero-filled.
- `MEM_WAIT_EN`, default 1: 1 = MEM/WB wait for `memReady`; 0 = `memReady` ignored, treated as 1.
- `MEM_TIMEOUT`, default 16: maximum wait cycles in MEM before abort; 0 disables the watchdog.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `instrCode` in 32: instruction word; must be held stable from DECODE to the end of the instruction.
- `memReady` in 1: data memory completed the access this cycle.
- `irWe` out 1: latch instruction register (FETCH).
- `pcEn` out 1: update PC (last cycle of the instruction).
- `regFileWe` out 1.
- `aluSrcMuxSel` out 1: 0 = rs2, 1 = imm.
- `aluControl` out `ALU_CTRL_W`.
- `dataWe` out 1 / `dataRe` out 1.
- `RFWDSrcMuxSel` out 3: 0 ALU, 1 dmem, 2 imm, 3 PC+imm, 4 PC+4.
- `shamt_signal` out 1: I-type shift (funct3 001/101).
- `branch`, `jal`, `jalr` out 1 each: PC-source qualifiers.
- `illegalInstr` out 1: one-cycle pulse.
- `busError` out 1: one-cycle pulse on timeout.

## Operation
- States: FETCH → DECODE → EXECUTE → {MEM → WB}.
- FETCH: `irWe`=1, then go to DECODE.
- DECODE: registers only. An unknown opcode pulses `illegalInstr` and `pcEn`, then returns to FETCH.
- EXECUTE:
  - R/I/B/LU/AU/J/JL: `pcEn`=1; `regFileWe`=1 except B; then FETCH.
  - S/L: go to MEM.
- MEM:
  - S holds `dataWe`=1; L holds `dataRe`=1.
  - Exit when `memReady`: S goes to FETCH with `pcEn`=1; L goes to WB.
- WB (L only): `regFileWe`=1, `RFWDSrcMuxSel`=1, `pcEn`=1, then FETCH.
- `aluControl`:
  - R: {funct7[5], funct3}.
  - I: {funct7[5], funct3} if funct3=101, else {0, funct3}.
  - B: {0, funct3}.
  - L/S/LU/AU/J/JL: ADD (0000).
- `aluSrcMuxSel`=1 for I/L/S/AU/JL.
- Writeback source `RFWDSrcMuxSel`: LU 2, AU 3, J/JL 4.
- `branch`/`jal`/`jalr` are asserted only in EXECUTE for their type.
- Watchdog:
  - Counter clears on entry to MEM and increments each MEM cycle without `memReady`.
  - When the count reaches `MEM_TIMEOUT`: pulse `busError`, deassert `dataWe`/`dataRe`, pulse `pcEn` (skip the instruction), go to FETCH. No register write occurs.
  - `memReady` in the same cycle as the timeout takes precedence: normal completion.
- Outputs are decoded from the registered state plus `instrCode`. While `reset`=1, all enables/pulses are forced to 0 combinationally.

## Timing
- Latency: R/I/B/LU/AU/J/JL take 3 cycles; S takes 4+w; L takes 5+w (w = MEM wait cycles).
- With `MEM_WAIT_EN`=0: S takes 4, L takes 5.
- Reset:
  - State becomes FETCH at the next edge; the counter clears.
  - All outputs are 0 during reset, except `aluControl`=0.
  - First FETCH (`irWe`=1) occurs in the cycle after `reset` deasserts.
- Reset during MEM aborts the access: `dataWe` drops in the same cycle reset rises, and no `pcEn` is issued.
- Each pulse output (`pcEn`, `illegalInstr`, `busError`, `irWe`) is exactly one cycle wide per instruction.

## Structure
- Shared `rv32_pkg`:
  - opcode constants (OP_TYPE_R/I/L/S/B/LU/AU/J/JL);
  - ALU op constants;
  - RFWD select constants;
  - state enum `mc_state_e`.
- Sub-module `rv32_instr_decoder` (combinational): produces type flags, `aluControl`, and `shamt_signal` from `instrCode`.
- The top level holds the FSM, the watchdog counter (width `$clog2(MEM_TIMEOUT+1)`), and output gating.

## Test plan
- ADD (0x00B50533) after reset → `irWe` at cycle 0; `regFileWe`=1, `pcEn`=1, `aluControl`=0000 at cycle 2; idle otherwise.
- SRAI (0x4025D513) → `shamt_signal`=1, `aluControl`=1101, `aluSrcMuxSel`=1 in EXECUTE.
- LW with `memReady` after 3 cycles → `dataRe` high for 4 MEM cycles, then WB with `regFileWe`=1 and `RFWDSrcMuxSel`=1; total 8 cycles.
- SW with `memReady` held 0 and `MEM_TIMEOUT`=16 → `dataWe` high for 16 cycles, then a `busError` pulse with `pcEn`, back to FETCH, and no `regFileWe`.
- Opcode 0x7F → `illegalInstr` and `pcEn` pulse in DECODE, FETCH next cycle. JAL → `jal`=1 and `RFWDSrcMuxSel`=4 in EXECUTE.
- `reset` asserted mid-MEM of SW → `dataWe`=0 the same cycle, FETCH after release, no `pcEn` pulse.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32I definitions for the multi-cycle control unit: opcodes, ALU ops,
// writeback-source selects, FSM state encoding and decoded instruction-class flags.
package rv32_pkg;

    localparam logic [6:0] OP_TYPE_R  = 7'b0110011;
    localparam logic [6:0] OP_TYPE_I  = 7'b0010011;
    localparam logic [6:0] OP_TYPE_L  = 7'b0000011;
    localparam logic [6:0] OP_TYPE_S  = 7'b0100011;
    localparam logic [6:0] OP_TYPE_B  = 7'b1100011;
    localparam logic [6:0] OP_TYPE_LU = 7'b0110111;
    localparam logic [6:0] OP_TYPE_AU = 7'b0010111;
    localparam logic [6:0] OP_TYPE_J  = 7'b1101111;
    localparam logic [6:0] OP_TYPE_JL = 7'b1100111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    localparam logic [2:0] RFWD_ALU    = 3'd0;
    localparam logic [2:0] RFWD_DMEM   = 3'd1;
    localparam logic [2:0] RFWD_IMM    = 3'd2;
    localparam logic [2:0] RFWD_PC_IMM = 3'd3;
    localparam logic [2:0] RFWD_PC_4   = 3'd4;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4
    } mc_state_e;

    typedef struct packed {
        logic r;
        logic i;
        logic l;
        logic s;
        logic b;
        logic lu;
        logic au;
        logic j;
        logic jl;
        logic illegal;
    } instr_type_t;

endpackage

// File: rtl/rv32_instr_decoder.sv
// Combinational RV32I field decoder: instruction class flags, ALU opcode and
// I-type shift indication taken straight from the latched instruction word.
module rv32_instr_decoder
    import rv32_pkg::*;
#(
    parameter int ALU_CTRL_W = 4
) (
    input  logic [31:0]           instrCode,
    output instr_type_t           itype,
    output logic [ALU_CTRL_W-1:0] aluControl,
    output logic                  shamt_signal
);

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic       funct7_b5_s;
    logic [3:0] alu_op_s;
    logic       unused_bits_s;

    assign opcode_s      = instrCode[6:0];
    assign funct3_s      = instrCode[14:12];
    assign funct7_b5_s   = instrCode[30];
    assign unused_bits_s = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

    // Classify the opcode and derive the ALU operation for that class.
    always_comb begin
        itype        = '0;
        alu_op_s     = ALU_ADD;
        shamt_signal = 1'b0;
        case (opcode_s)
            OP_TYPE_R: begin
                itype.r  = 1'b1;
                alu_op_s = {funct7_b5_s, funct3_s};
            end
            OP_TYPE_I: begin
                itype.i = 1'b1;
                // Only the right shifts use bit 30 to pick SRA vs SRL; elsewhere it is immediate data.
                if (funct3_s == 3'b101) begin
                    alu_op_s = {funct7_b5_s, funct3_s};
                end else begin
                    alu_op_s = {1'b0, funct3_s};
                end
                shamt_signal = (funct3_s == 3'b001) || (funct3_s == 3'b101);
            end
            OP_TYPE_B: begin
                itype.b  = 1'b1;
                alu_op_s = {1'b0, funct3_s};
            end
            OP_TYPE_L:  itype.l  = 1'b1;
            OP_TYPE_S:  itype.s  = 1'b1;
            OP_TYPE_LU: itype.lu = 1'b1;
            OP_TYPE_AU: itype.au = 1'b1;
            OP_TYPE_J:  itype.j  = 1'b1;
            OP_TYPE_JL: itype.jl = 1'b1;
            default:    itype.illegal = 1'b1;
        endcase
    end

    assign aluControl = ALU_CTRL_W'(alu_op_s);

endmodule

// File: rtl/rv32_mc_control_unit.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXECUTE/MEM/WB sequencing,
// data-memory handshake with timeout watchdog, and datapath enable generation.
module rv32_mc_control_unit
    import rv32_pkg::*;
#(
    parameter int ALU_CTRL_W  = 4,
    parameter int MEM_WAIT_EN = 1,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           instrCode,
    input  logic                  memReady,
    output logic                  irWe,
    output logic                  pcEn,
    output logic                  regFileWe,
    output logic                  aluSrcMuxSel,
    output logic [ALU_CTRL_W-1:0] aluControl,
    output logic                  dataWe,
    output logic                  dataRe,
    output logic [2:0]            RFWDSrcMuxSel,
    output logic                  shamt_signal,
    output logic                  branch,
    output logic                  jal,
    output logic                  jalr,
    output logic                  illegalInstr,
    output logic                  busError
);

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    mc_state_e             state_r;
    mc_state_e             state_next_s;
    logic [CNT_W-1:0]      wait_cnt_r;
    instr_type_t           itype_s;
    logic [ALU_CTRL_W-1:0] dec_alu_s;
    logic                  dec_shamt_s;
    logic                  ready_s;
    logic                  timeout_s;
    logic                  mem_op_s;

    rv32_instr_decoder #(
        .ALU_CTRL_W (ALU_CTRL_W)
    ) u_decoder (
        .instrCode    (instrCode),
        .itype        (itype_s),
        .aluControl   (dec_alu_s),
        .shamt_signal (dec_shamt_s)
    );

    assign ready_s  = (MEM_WAIT_EN != 0) ? memReady : 1'b1;
    assign mem_op_s = itype_s.s | itype_s.l;
    // A ready in the timeout cycle wins, so the watchdog only fires without it.
    assign timeout_s = (MEM_TIMEOUT != 0) && (state_r == ST_MEM) && !ready_s
                       && (wait_cnt_r == CNT_W'(MEM_TIMEOUT));

    // Next-state selection.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_FETCH:   state_next_s = ST_DECODE;
            ST_DECODE: begin
                if (itype_s.illegal) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (mem_op_s) begin
                    state_next_s = ST_MEM;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_MEM: begin
                if (ready_s) begin
                    state_next_s = itype_s.l ? ST_WB : ST_FETCH;
                end else if (timeout_s) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_MEM;
                end
            end
            ST_WB:      state_next_s = ST_FETCH;
            default:    state_next_s = ST_FETCH;
        endcase
    end

    // State register and MEM wait counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_FETCH;
            wait_cnt_r <= '0;
        end else begin
            state_r <= state_next_s;
            if (state_r != ST_MEM) begin
                wait_cnt_r <= '0;
            end else if (!ready_s && !timeout_s && (MEM_TIMEOUT != 0)) begin
                wait_cnt_r <= wait_cnt_r + CNT_W'(1);
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
        end
    end

    // Datapath controls from state and instruction; everything is held low in reset.
    always_comb begin
        irWe          = 1'b0;
        pcEn          = 1'b0;
        regFileWe     = 1'b0;
        aluSrcMuxSel  = 1'b0;
        aluControl    = '0;
        dataWe        = 1'b0;
        dataRe        = 1'b0;
        RFWDSrcMuxSel = RFWD_ALU;
        shamt_signal  = 1'b0;
        branch        = 1'b0;
        jal           = 1'b0;
        jalr          = 1'b0;
        illegalInstr  = 1'b0;
        busError      = 1'b0;
        if (reset) begin
            irWe = 1'b0;
        end else begin
            case (state_r)
                ST_FETCH:  irWe = 1'b1;
                ST_DECODE: begin
                    illegalInstr = itype_s.illegal;
                    pcEn         = itype_s.illegal;
                end
                ST_EXECUTE: begin
                    aluControl   = dec_alu_s;
                    shamt_signal = dec_shamt_s;
                    aluSrcMuxSel = itype_s.i | itype_s.l | itype_s.s | itype_s.au | itype_s.jl;
                    pcEn         = !mem_op_s;
                    regFileWe    = itype_s.r | itype_s.i | itype_s.lu | itype_s.au
                                   | itype_s.j | itype_s.jl;
                    branch       = itype_s.b;
                    jal          = itype_s.j;
                    jalr         = itype_s.jl;
                    if (itype_s.lu) begin
                        RFWDSrcMuxSel = RFWD_IMM;
                    end else if (itype_s.au) begin
                        RFWDSrcMuxSel = RFWD_PC_IMM;
                    end else if (itype_s.j | itype_s.jl) begin
                        RFWDSrcMuxSel = RFWD_PC_4;
                    end else begin
                        RFWDSrcMuxSel = RFWD_ALU;
                    end
                end
                ST_MEM: begin
                    aluControl   = dec_alu_s;
                    aluSrcMuxSel = 1'b1;
                    dataWe       = itype_s.s & !timeout_s;
                    dataRe       = itype_s.l & !timeout_s;
                    busError     = timeout_s;
                    pcEn         = timeout_s | (itype_s.s & ready_s);
                end
                ST_WB: begin
                    regFileWe     = 1'b1;
                    RFWDSrcMuxSel = RFWD_DMEM;
                    pcEn          = 1'b1;
                end
                default: irWe = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_mc_control_unit.sv
// Self-checking bench for rv32_mc_control_unit: per-cycle expected output vectors
// are queued as stimulus is applied and compared on the falling edge.
module tb_rv32_mc_control_unit;

    typedef struct packed {
        logic       ir;
        logic       pc;
        logic       rfwe;
        logic       asrc;
        logic [3:0] alu;
        logic       dwe;
        logic       dre;
        logic [2:0] rfwd;
        logic       sh;
        logic       br;
        logic       jal;
        logic       jalr;
        logic       ill;
        logic       berr;
    } out_t;

    typedef struct {
        out_t  o;
        string nm;
    } sb_t;

    typedef struct {
        logic [31:0] instr;
        out_t        exe;
        string       nm;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instrCode;
    logic        memReady;
    logic        irWe, pcEn, regFileWe, aluSrcMuxSel, dataWe, dataRe;
    logic [3:0]  aluControl;
    logic [2:0]  RFWDSrcMuxSel;
    logic        shamt_signal, branch, jal, jalr, illegalInstr, busError;

    out_t act;
    sb_t  q[$];
    sb_t  ent;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t tbl[12];

    rv32_mc_control_unit #(
        .ALU_CTRL_W  (4),
        .MEM_WAIT_EN (1),
        .MEM_TIMEOUT (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .instrCode     (instrCode),
        .memReady      (memReady),
        .irWe          (irWe),
        .pcEn          (pcEn),
        .regFileWe     (regFileWe),
        .aluSrcMuxSel  (aluSrcMuxSel),
        .aluControl    (aluControl),
        .dataWe        (dataWe),
        .dataRe        (dataRe),
        .RFWDSrcMuxSel (RFWDSrcMuxSel),
        .shamt_signal  (shamt_signal),
        .branch        (branch),
        .jal           (jal),
        .jalr          (jalr),
        .illegalInstr  (illegalInstr),
        .busError      (busError)
    );

    always #5 clk = ~clk;

    assign act = '{ir: irWe, pc: pcEn, rfwe: regFileWe, asrc: aluSrcMuxSel, alu: aluControl,
                   dwe: dataWe, dre: dataRe, rfwd: RFWDSrcMuxSel, sh: shamt_signal,
                   br: branch, jal: jal, jalr: jalr, ill: illegalInstr, berr: busError};

    // Scoreboard: compare the oldest expected vector mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            ent = q.pop_front();
            n_checks++;
            if (act !== ent.o) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", ent.nm, act, ent.o);
            end
        end
    end

    function automatic out_t zero();
        out_t o;
        o = '0;
        return o;
    endfunction

    function automatic out_t exe(input logic rfwe, input logic asrc, input logic [3:0] alu,
                                 input logic [2:0] rfwd, input logic sh, input logic br,
                                 input logic j, input logic jr);
        out_t o;
        o      = '0;
        o.pc   = 1'b1;
        o.rfwe = rfwe;
        o.asrc = asrc;
        o.alu  = alu;
        o.rfwd = rfwd;
        o.sh   = sh;
        o.br   = br;
        o.jal  = j;
        o.jalr = jr;
        return o;
    endfunction

    task automatic drive(input out_t e, input string nm);
        q.push_back('{o: e, nm: nm});
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input logic [31:0] instr, input string nm);
        out_t f;
        f    = '0;
        f.ir = 1'b1;
        instrCode = instr;
        memReady  = 1'b0;
        drive(f, {nm, "_fetch"});
        drive(zero(), {nm, "_decode"});
    endtask

    task automatic mem_prefix(input logic [31:0] instr, input string nm);
        out_t e;
        e      = '0;
        e.asrc = 1'b1;
        fetch_decode(instr, nm);
        drive(e, {nm, "_execute"});
    endtask

    initial begin
        out_t m;
        out_t t;
        tbl[0]  = '{32'h00B50533, exe(1'b1, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0), "add"};
        tbl[1]  = '{32'h40B50533, exe(1'b1, 1'b0, 4'b1000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0), "sub"};
        tbl[2]  = '{32'h4025D513, exe(1'b1, 1'b1, 4'b1101, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0), "srai"};
        tbl[3]  = '{32'h00351513, exe(1'b1, 1'b1, 4'b0001, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0), "slli"};
        tbl[4]  = '{32'h00554513, exe(1'b1, 1'b1, 4'b0100, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0), "xori"};
        tbl[5]  = '{32'h40050513, exe(1'b1, 1'b1, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0), "addi_b30"};
        tbl[6]  = '{32'h00B54463, exe(1'b0, 1'b0, 4'b0100, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0), "blt"};
        tbl[7]  = '{32'h123452B7, exe(1'b1, 1'b0, 4'b0000, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0), "lui"};
        tbl[8]  = '{32'h12345297, exe(1'b1, 1'b1, 4'b0000, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0), "auipc"};
        tbl[9]  = '{32'h008000EF, exe(1'b1, 1'b0, 4'b0000, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0), "jal"};
        tbl[10] = '{32'h000080E7, exe(1'b1, 1'b1, 4'b0000, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1), "jalr"};
        tbl[11] = '{32'h40B50533, exe(1'b1, 1'b0, 4'b1000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0), "sub2"};

        reset     = 1'b1;
        instrCode = 32'h00B50533;
        memReady  = 1'b0;
        @(posedge clk);
        #1;
        drive(zero(), "reset_0");
        drive(zero(), "reset_1");
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            fetch_decode(tbl[i].instr, tbl[i].nm);
            drive(tbl[i].exe, {tbl[i].nm, "_execute"});
        end

        // LW with ready on the 4th MEM cycle, then writeback.
        mem_prefix(32'h0005A503, "lw");
        m      = '0;
        m.asrc = 1'b1;
        m.dre  = 1'b1;
        for (int i = 0; i < 3; i++) drive(m, "lw_mem_wait");
        memReady = 1'b1;
        drive(m, "lw_mem_ready");
        memReady = 1'b0;
        t      = '0;
        t.rfwe = 1'b1;
        t.rfwd = 3'd1;
        t.pc   = 1'b1;
        drive(t, "lw_wb");

        // SW with no ready: 16 wait cycles then watchdog abort.
        mem_prefix(32'h00A5A023, "sw_to");
        m      = '0;
        m.asrc = 1'b1;
        m.dwe  = 1'b1;
        for (int i = 0; i < 16; i++) drive(m, "sw_to_mem");
        t      = '0;
        t.asrc = 1'b1;
        t.berr = 1'b1;
        t.pc   = 1'b1;
        drive(t, "sw_to_buserr");

        // SW with ready arriving exactly in the timeout cycle: normal completion.
        mem_prefix(32'h00A5A023, "sw_edge");
        for (int i = 0; i < 16; i++) drive(m, "sw_edge_mem");
        memReady = 1'b1;
        t      = m;
        t.pc   = 1'b1;
        drive(t, "sw_edge_done");
        memReady = 1'b0;

        // Illegal opcode: pulse in DECODE, FETCH follows.
        instrCode = 32'h0000007F;
        t      = '0;
        t.ir   = 1'b1;
        drive(t, "ill_fetch");
        t      = '0;
        t.ill  = 1'b1;
        t.pc   = 1'b1;
        drive(t, "ill_decode");
        fetch_decode(tbl[0].instr, "add_after_ill");
        drive(tbl[0].exe, "add_after_ill_execute");

        // Reset during MEM of a store drops dataWe at once and issues no pcEn.
        mem_prefix(32'h00A5A023, "sw_rst");
        for (int i = 0; i < 2; i++) drive(m, "sw_rst_mem");
        reset = 1'b1;
        drive(zero(), "sw_rst_in_reset0");
        drive(zero(), "sw_rst_in_reset1");
        reset = 1'b0;
        fetch_decode(tbl[9].instr, "jal_after_rst");
        drive(tbl[9].exe, "jal_after_rst_execute");

        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
